// File: rtl/bc_input_port.sv
// Keyboard-side input stage: valid/ready FIFO feeding the INPR register and FGI flag.
// Define BC_INPUT_PORT_PARITY_EN to drop odd-parity bytes and count them in err_cnt.
module bc_input_port #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [7:0]                 in_data,
    input  logic                       in_parity,
    output logic                       in_ready,
    input  logic                       inp_ack,
    output logic [7:0]                 INPR,
    output logic                       FGI,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic [7:0]                 err_cnt
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      inpr_q;
    logic            accept;
    logic            push;
    logic            load;

    // Full blocks acceptance even if a pop lands on the same edge.
    assign in_ready   = (level_q != LW'(DEPTH));
    assign accept     = in_valid & in_ready;
    assign fifo_level = level_q;
    assign INPR       = inpr_q;
    assign FGI        = (state_q == StFull);

`ifdef BC_INPUT_PORT_PARITY_EN
    logic       parity_ok;
    logic [7:0] err_q;

    assign parity_ok = ~^{in_data, in_parity};
    assign push      = accept & parity_ok;
    assign err_cnt   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 8'h00;
        end else if (accept && !parity_ok && err_q != 8'hFF) begin
            err_q <= err_q + 8'd1;
        end
    end
`else
    logic unused_parity;

    assign unused_parity = in_parity;
    assign push          = accept;
    assign err_cnt       = 8'h00;
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        unique case (state_q)
            StEmpty: begin
                if (level_q != '0) begin
                    load    = 1'b1;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (inp_ack) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (push && !load) begin
            level_d = level_q + LW'(1);
        end else if (!push && load) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StEmpty;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            inpr_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (load) begin
                inpr_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Storage needs no reset: level and pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_bc_input_port.sv
// Directed bench for bc_input_port (DEPTH = 4); follows the parity macro if defined.
module tb_bc_input_port;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_parity;
    logic       in_ready;
    logic       inp_ack;
    logic [7:0] INPR;
    logic       FGI;
    logic [2:0] fifo_level;
    logic [7:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];

    bc_input_port #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_parity  (in_parity),
        .in_ready   (in_ready),
        .inp_ack    (inp_ack),
        .INPR       (INPR),
        .FGI        (FGI),
        .fifo_level (fifo_level),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d);
        in_data   = d;
        in_parity = ^d;
    endtask

    // Feeds tx_q through the handshake, acks every ack_every cycles while FGI is set,
    // and records each load (FGI rising) into rx_q.
    task automatic run_stream(input int ack_every, input int budget);
        int   cyc = 0;
        int   idx = 0;
        logic sent;
        logic prev;
        rx_q.delete();
        while (rx_q.size() < exp_q.size() && cyc < budget) begin
            in_valid = (idx < tx_q.size());
            if (in_valid) drive(tx_q[idx]);
            inp_ack = FGI && (cyc % ack_every == 0);
            sent    = in_valid && in_ready;
            prev    = FGI;
            tick();
            if (sent) idx++;
            if (!prev && FGI) rx_q.push_back(INPR);
            cyc++;
        end
        in_valid = 1'b0;
        inp_ack  = 1'b0;
        check("stream_count", rx_q.size(), exp_q.size());
        check("stream_sent", idx, tx_q.size());
        foreach (exp_q[i]) begin
            if (i < rx_q.size()) check($sformatf("stream_byte%0d", i), rx_q[i], exp_q[i]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_parity = 1'b0;
        inp_ack   = 1'b0;
        tick();
        tick();
        check("rst_inpr", INPR, 8'h00);
        check("rst_fgi", FGI, 1'b0);
        check("rst_ready", in_ready, 1'b1);
        check("rst_level", fifo_level, 3'd0);
        check("rst_err", err_cnt, 8'h00);
        rst = 1'b0;
        tick();

        // Single character: two-edge latency, ack clears FGI, INPR holds.
        in_valid = 1'b1;
        drive(8'h41);
        tick();
        in_valid = 1'b0;
        check("single_fgi_n", FGI, 1'b0);
        check("single_level_n", fifo_level, 3'd1);
        tick();
        check("single_fgi_n1", FGI, 1'b1);
        check("single_inpr_n1", INPR, 8'h41);
        check("single_level_n1", fifo_level, 3'd0);
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        check("ack_fgi", FGI, 1'b0);
        check("ack_inpr", INPR, 8'h41);

        // Spurious ack with FGI low.
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;
        check("spur_fgi", FGI, 1'b0);
        check("spur_level", fifo_level, 3'd0);
        check("spur_inpr", INPR, 8'h41);

        // Fill: 41 loads while 42 pushes (level unchanged), then 43..45 fill, 46 is held.
        in_valid = 1'b1;
        drive(8'h41);
        tick();
        check("fill_level1", fifo_level, 3'd1);
        drive(8'h42);
        tick();
        check("push_load_level", fifo_level, 3'd1);
        check("fill_fgi", FGI, 1'b1);
        check("fill_inpr", INPR, 8'h41);
        drive(8'h43);
        tick();
        drive(8'h44);
        tick();
        drive(8'h45);
        tick();
        check("full_level", fifo_level, 3'd4);
        check("full_ready", in_ready, 1'b0);
        drive(8'h46);
        tick();
        check("held_level", fifo_level, 3'd4);
        check("held_ready", in_ready, 1'b0);
        check("held_inpr", INPR, 8'h41);
        check("held_fgi", FGI, 1'b1);

        // Drain in order; 46 enters once space frees.
        tx_q  = '{8'h46};
        exp_q = '{8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        run_stream(1, 100);

        // Acknowledge the last char so the wrap stream starts with FGI low.
        inp_ack = 1'b1;
        tick();
        inp_ack = 1'b0;

        // Wrap-around: 10 characters, ack every 3 cycles.
        tx_q  = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h59};
        exp_q = tx_q;
        run_stream(3, 300);
        check("wrap_level", fifo_level, 3'd0);
        check("wrap_fgi", FGI, 1'b1);

        // Parity: 41 has even weight, so parity 1 is an error and parity 0 is good.
        in_valid  = 1'b1;
        in_data   = 8'h41;
        in_parity = 1'b1;
        tick();
`ifdef BC_INPUT_PORT_PARITY_EN
        check("par_bad_level", fifo_level, 3'd0);
        check("par_bad_err", err_cnt, 8'd1);
`else
        check("par_bad_level", fifo_level, 3'd1);
        check("par_bad_err", err_cnt, 8'd0);
`endif
        in_parity = 1'b0;
        tick();
        in_valid = 1'b0;
`ifdef BC_INPUT_PORT_PARITY_EN
        check("par_good_level", fifo_level, 3'd1);
        check("par_good_err", err_cnt, 8'd1);
`else
        check("par_good_level", fifo_level, 3'd2);
        check("par_good_err", err_cnt, 8'd0);
`endif

        // Asynchronous reset mid-cycle discards buffered state immediately.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_inpr", INPR, 8'h00);
        check("arst_fgi", FGI, 1'b0);
        check("arst_ready", in_ready, 1'b1);
        check("arst_level", fifo_level, 3'd0);
        check("arst_err", err_cnt, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_fgi", FGI, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
